// File: rtl/rx_uart.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling from a fixed
// clock-per-baud divider, start-glitch rejection and framing-error reporting.
module rx_uart #(
    parameter int unsigned DATA_BITS       = 8,
    parameter int unsigned TIMER_BITS      = 32,
    parameter int unsigned CLOCKS_PER_BAUD = 868
) (
    input  logic                 clk,
    input  logic                 i_reset,
    input  logic                 uart_txd_in,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_frame_err,
    output logic                 o_busy
);

    localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [TIMER_BITS-1:0] HALF_RELOAD = TIMER_BITS'(CLOCKS_PER_BAUD / 2 - 1);
    localparam logic [TIMER_BITS-1:0] FULL_RELOAD = TIMER_BITS'(CLOCKS_PER_BAUD - 1);
    localparam logic [TIMER_BITS-1:0] TIMER_ONE   = TIMER_BITS'(1);
    localparam logic [IDX_W-1:0]      LAST_IDX    = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0]      IDX_ONE     = IDX_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t                state;
    logic [TIMER_BITS-1:0] clk_counter;
    logic [DATA_BITS-1:0]  shift;
    logic [IDX_W-1:0]      bit_idx;
    logic                  sync_1;
    logic                  rx_s;
    logic                  sample;

    // Both stages reset high so a reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            sync_1 <= 1'b1;
            rx_s   <= 1'b1;
        end else begin
            sync_1 <= uart_txd_in;
            rx_s   <= sync_1;
        end
    end

    always_comb begin
        sample = (clk_counter == '0);
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state       <= IDLE;
            clk_counter <= '0;
            shift       <= '0;
            bit_idx     <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state       <= START;
                        clk_counter <= HALF_RELOAD;
                    end
                end
                START: begin
                    if (sample) begin
                        if (!rx_s) begin
                            state       <= DATA;
                            clk_counter <= FULL_RELOAD;
                            bit_idx     <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        clk_counter <= clk_counter - TIMER_ONE;
                    end
                end
                DATA: begin
                    if (sample) begin
                        shift       <= {rx_s, shift[DATA_BITS-1:1]};
                        bit_idx     <= bit_idx + IDX_ONE;
                        clk_counter <= FULL_RELOAD;
                        if (bit_idx == LAST_IDX) begin
                            state <= STOP;
                        end
                    end else begin
                        clk_counter <= clk_counter - TIMER_ONE;
                    end
                end
                STOP: begin
                    if (sample) begin
                        if (rx_s) begin
                            o_data  <= shift;
                            o_valid <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            o_frame_err <= 1'b1;
                            state       <= WAIT_IDLE;
                        end
                    end else begin
                        clk_counter <= clk_counter - TIMER_ONE;
                    end
                end
                // A held-low line (break) parks here so it cannot retrigger.
                WAIT_IDLE: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        o_busy = (state != IDLE);
    end

endmodule

// File: tb/tb_rx_uart.sv
// Randomised bench for rx_uart: pre-built line/reset schedule, an event-level
// receiver model over that schedule, and a per-cycle compare against the DUT.
module tb_rx_uart;

    localparam int C = 16;
    localparam int N = 80000;

    logic       clk;
    logic       i_reset;
    logic       uart_txd_in;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_busy;

    rx_uart #(
        .DATA_BITS(8),
        .TIMER_BITS(32),
        .CLOCKS_PER_BAUD(C)
    ) dut (
        .clk(clk),
        .i_reset(i_reset),
        .uart_txd_in(uart_txd_in),
        .o_data(o_data),
        .o_valid(o_valid),
        .o_frame_err(o_frame_err),
        .o_busy(o_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // line[k] / rst[k] are the pin and reset values sampled at rising edge k.
    logic       line [N];
    logic       rst  [N];
    logic       exp_valid [N];
    logic       exp_err   [N];
    logic       exp_busy  [N];
    logic [7:0] exp_byte  [N];

    int pos;
    int errors;
    int checks;

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, k, act, exp);
        end
    endtask

    task automatic put(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            if (pos < N - 400) begin
                line[pos] = v;
                pos++;
            end
        end
    endtask

    task automatic frame(input logic [7:0] b, input logic stopv);
        put(1'b0, C);
        for (int i = 0; i < 8; i++) put(b[i], C);
        put(stopv, C);
    endtask

    // Synchronised line as the receiver sees it during cycle k.
    function automatic logic rxs(input int k);
        if (k <= 0 || rst[k] || rst[k-1]) return 1'b1;
        return line[k-1];
    endfunction

    function automatic int cnt(input int kind, input int a, input int b);
        int n = 0;
        for (int i = a; i < b; i++) begin
            if (kind == 0 && exp_valid[i]) n++;
            if (kind == 1 && exp_err[i]) n++;
            if (kind == 2 && exp_busy[i]) n++;
        end
        return n;
    endfunction

    task automatic set_busy(input int a, input int b);
        for (int i = a; i <= b; i++) exp_busy[i] = 1'b1;
    endtask

    // Frame-level model: find a falling edge, then look at the fixed mid-bit
    // sample instants; any reset inside the frame window aborts it silently.
    task automatic run_model(input int len);
        int k, r, j, st, s, w;
        logic [7:0] b;
        k = 0;
        while (k < len) begin
            if (rxs(k) != 1'b0) begin
                k++;
                continue;
            end
            r  = k;
            st = r + C/2;
            s  = r + C/2 + 9*C;
            j  = -1;
            for (int i = r + 1; i <= s + 1; i++) begin
                if (j < 0 && rst[i]) j = i;
            end
            if (j >= 0 && j <= st) begin
                set_busy(r + 1, j - 1);
                k = j;
                continue;
            end
            if (rxs(st) == 1'b1) begin
                set_busy(r + 1, st);
                k = st + 1;
                continue;
            end
            if (j >= 0) begin
                set_busy(r + 1, j - 1);
                k = j;
                continue;
            end
            for (int i = 0; i < 8; i++) b[i] = rxs(r + C/2 + (i + 1)*C);
            set_busy(r + 1, s);
            if (rxs(s) == 1'b1) begin
                exp_valid[s+1] = 1'b1;
                exp_byte[s+1]  = b;
                k = s + 1;
            end else begin
                exp_err[s+1] = 1'b1;
                w = s + 1;
                while (w < N - 1 && rxs(w) == 1'b0) w++;
                if (rst[w]) begin
                    set_busy(s + 1, w - 1);
                    k = w;
                end else begin
                    set_busy(s + 1, w);
                    k = w + 1;
                end
            end
        end
    endtask

    int t1, t2, t3, t3b, t4, t5, t34, tl, len;
    logic [7:0] exp_d;
    int choice;

    initial begin
        errors = 0;
        checks = 0;
        pos    = 0;
        for (int i = 0; i < N; i++) begin
            line[i] = 1'b1; rst[i] = 1'b0;
            exp_valid[i] = 1'b0; exp_err[i] = 1'b0; exp_busy[i] = 1'b0; exp_byte[i] = '0;
        end
        for (int i = 0; i < 4; i++) rst[i] = 1'b1;
        put(1'b1, 20);

        t1 = pos;  frame(8'h55, 1'b1); put(1'b1, 20);
        t2 = pos;  frame(8'hA5, 1'b1); frame(8'h3C, 1'b1); put(1'b1, 20);
        t3 = pos;  put(1'b0, 3); put(1'b1, 30);
        t3b = pos; frame(8'h81, 1'b1); put(1'b1, 20);
        t4 = pos;  frame(8'hFF, 1'b0); put(1'b0, 100); put(1'b1, 30);
        t5 = pos;  frame(8'h12, 1'b1);
        rst[t5 + 88] = 1'b1;
        pos = t5 + 88; put(1'b1, 40);
        t34 = pos; frame(8'h34, 1'b1); put(1'b1, 20);
        tl = pos;
        for (int i = 0; i < 256; i++) frame(8'(i), 1'b1);
        put(1'b1, 20);

        for (int it = 0; it < 90; it++) begin
            choice = $urandom_range(0, 9);
            if (choice == 0) begin
                put(1'b0, $urandom_range(1, 7));
                put(1'b1, $urandom_range(1, 20));
            end else if (choice == 1) begin
                frame(8'($urandom), 1'b0);
                put(1'b0, $urandom_range(0, 40));
                put(1'b1, $urandom_range(1, 20));
            end else if (choice == 2) begin
                rst[pos + $urandom_range(0, 150)] = 1'b1;
                frame(8'($urandom), 1'b1);
            end else begin
                frame(8'($urandom), 1'b1);
                put(1'b1, $urandom_range(0, 12));
            end
        end
        put(1'b1, 300);
        len = pos;

        run_model(len);

        // Hand-derived anchors for the model.
        check("m_t1_valid", t1 + 154, 32'(exp_valid[t1 + 154]), 32'd1);
        check("m_t1_byte", t1 + 154, 32'(exp_byte[t1 + 154]), 32'h55);
        check("m_b2b_first", t2 + 154, 32'(exp_byte[t2 + 154]), 32'hA5);
        check("m_b2b_second", t2 + 314, 32'(exp_valid[t2 + 314]), 32'd1);
        check("m_b2b_byte", t2 + 314, 32'(exp_byte[t2 + 314]), 32'h3C);
        check("m_glitch_busy", t3, 32'(cnt(2, t3, t3 + 30)), 32'd8);
        check("m_glitch_quiet", t3, 32'(cnt(0, t3, t3 + 30) + cnt(1, t3, t3 + 30)), 32'd0);
        check("m_after_glitch", t3b + 154, 32'(exp_byte[t3b + 154]), 32'h81);
        check("m_ferr_pulse", t4 + 154, 32'(exp_err[t4 + 154]), 32'd1);
        check("m_ferr_count", t4, 32'(cnt(1, t4, t4 + 300)), 32'd1);
        check("m_ferr_novalid", t4, 32'(cnt(0, t4, t4 + 300)), 32'd0);
        check("m_break_busy_end", t4 + 261, 32'({exp_busy[t4 + 261], exp_busy[t4 + 262]}), 32'b10);
        check("m_reset_abort", t5, 32'(cnt(0, t5, t34) + cnt(1, t5, t34)), 32'd0);
        check("m_after_reset", t34 + 154, 32'(exp_byte[t34 + 154]), 32'h34);
        check("m_loop_count", tl, 32'(cnt(0, tl, tl + 256*160 + 1)), 32'd256);
        check("m_loop_noerr", tl, 32'(cnt(1, tl, tl + 256*160 + 1)), 32'd0);
        check("m_loop_last", tl + 154 + 255*160, 32'(exp_byte[tl + 154 + 255*160]), 32'hFF);

        uart_txd_in = line[0];
        i_reset     = rst[0];
        exp_d       = '0;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            if (rst[k]) exp_d = '0;
            if (exp_valid[k]) exp_d = exp_byte[k];
            check("o_valid", k, 32'(o_valid), 32'(exp_valid[k]));
            check("o_frame_err", k, 32'(o_frame_err), 32'(exp_err[k]));
            check("o_busy", k, 32'(o_busy), 32'(exp_busy[k]));
            check("o_data", k, 32'(o_data), 32'(exp_d));
            if (k == 2) check("reset_outputs", k, {o_data, o_valid, o_frame_err, o_busy}, 32'd0);
            if (k == t1 + 154) check("t1_pulse", k, {o_valid, o_data}, 32'h155);
            if (k == t1 + 155) check("t1_pulse_len", k, {o_valid, o_busy}, 32'd0);
            if (k == t2 + 314) check("b2b_second", k, {o_valid, o_data}, 32'h13C);
            if (k == t4 + 154) check("ferr_pulse", k, {o_frame_err, o_valid, o_data}, 32'h281);
            if (k == t5 + 88) check("reset_midframe", k, {o_data, o_valid, o_frame_err, o_busy}, 32'd0);
            if (k == t34 + 154) check("after_reset", k, {o_valid, o_data}, 32'h134);
            uart_txd_in = line[k+1];
            i_reset     = rst[k+1];
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
